// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared definitions for the round-robin decoder arbiter: state encoding,
// requester count and the rotating-priority search used to pick a winner.
package rr_decoder_arbiter_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        TURNAROUND = 2'd2
    } arb_state_t;

    // Returns {found, index}; scanning from the far end lets the requester
    // closest to ptr overwrite any later candidate.
    function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

endpackage

// File: rtl/rr_decoder_arbiter_grant_decoder.sv
// Enabled 2-to-4 decoder that turns the registered owner index into the
// one-hot select lines of the shared resource.
module grant_decoder_2to4
    import rr_decoder_arbiter_pkg::*;
(
    input  logic [1:0]         addr,
    input  logic               en,
    output logic [NUM_REQ-1:0] out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Four-requester round-robin arbiter with locked grants, bounded tenure
// pre-emption and a turnaround gap between consecutive owners.
module rr_decoder_arbiter
    import rr_decoder_arbiter_pkg::*;
#(
    parameter int MAX_HOLD    = 8,
    parameter int TURN_CYCLES = 1
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         grant_addr,
    output logic               grant_valid,
    output logic               busy
);

    localparam int TENURE_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [TENURE_W-1:0] HOLD_LIMIT = TENURE_W'(MAX_HOLD);
    localparam logic [3:0]          TURN_LIMIT = 4'(TURN_CYCLES);

    arb_state_t          state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          addr_q, addr_d;
    logic                valid_q, valid_d;
    logic [TENURE_W-1:0] tenure_q, tenure_d;
    logic [3:0]          turn_q, turn_d;

    logic [2:0]          pick;
    logic                owner_released;
    logic                others_waiting;
    logic                preempt;

    assign pick           = rr_pick(req, ptr_q);
    assign owner_released = !req[addr_q];
    assign others_waiting = |(req & ~(NUM_REQ'(1) << addr_q));
    assign preempt        = (MAX_HOLD != 0) && (tenure_q == HOLD_LIMIT) && others_waiting;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        tenure_d = tenure_q;
        turn_d   = turn_q;
        case (state_q)
            IDLE: begin
                if (pick[2]) begin
                    state_d  = GRANT;
                    addr_d   = pick[1:0];
                    valid_d  = 1'b1;
                    tenure_d = TENURE_W'(1);
                end
            end
            GRANT: begin
                if (owner_released || preempt) begin
                    state_d = TURNAROUND;
                    valid_d = 1'b0;
                    ptr_d   = addr_q + 2'd1;
                    turn_d  = 4'd1;
                end else if ((MAX_HOLD != 0) && (tenure_q != HOLD_LIMIT)) begin
                    tenure_d = tenure_q + TENURE_W'(1);
                end
            end
            TURNAROUND: begin
                // ptr already points past the previous owner, so the
                // search below naturally demotes it.
                if (turn_q == TURN_LIMIT) begin
                    if (pick[2]) begin
                        state_d  = GRANT;
                        addr_d   = pick[1:0];
                        valid_d  = 1'b1;
                        tenure_d = TENURE_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    turn_d = turn_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            addr_q   <= 2'd0;
            valid_q  <= 1'b0;
            tenure_q <= '0;
            turn_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            tenure_q <= tenure_d;
            turn_q   <= turn_d;
        end
    end

    assign grant_addr  = addr_q;
    assign grant_valid = valid_q;
    assign busy        = (state_q != IDLE);

    grant_decoder_2to4 u_decoder (
        .addr (addr_q),
        .en   (valid_q),
        .out  (grant)
    );

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Bench for rr_decoder_arbiter: four instances with different tenure and
// turnaround settings, directed scenarios plus a random run against a model.
module tb_rr_decoder_arbiter;

    localparam int N_INST = 4;
    localparam int MH[N_INST] = '{8, 4, 0, 1};
    localparam int TC[N_INST] = '{1, 1, 3, 15};

    logic       clk;
    logic       reset;
    logic [3:0] req;

    logic [3:0] grant_w [N_INST];
    logic [1:0] addr_w  [N_INST];
    logic       valid_w [N_INST];
    logic       busy_w  [N_INST];

    int checks;
    int failures;

    // Reference model: who owns the resource, how long they have held it,
    // how far into the gap we are, and where the rotating priority starts.
    int m_owner [N_INST];
    int m_held  [N_INST];
    int m_gap   [N_INST];
    int m_ptr   [N_INST];
    int m_last  [N_INST];

    rr_decoder_arbiter #(.MAX_HOLD(8), .TURN_CYCLES(1)) dut0 (
        .clk(clk), .reset(reset), .req(req), .grant(grant_w[0]),
        .grant_addr(addr_w[0]), .grant_valid(valid_w[0]), .busy(busy_w[0]));
    rr_decoder_arbiter #(.MAX_HOLD(4), .TURN_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .req(req), .grant(grant_w[1]),
        .grant_addr(addr_w[1]), .grant_valid(valid_w[1]), .busy(busy_w[1]));
    rr_decoder_arbiter #(.MAX_HOLD(0), .TURN_CYCLES(3)) dut2 (
        .clk(clk), .reset(reset), .req(req), .grant(grant_w[2]),
        .grant_addr(addr_w[2]), .grant_valid(valid_w[2]), .busy(busy_w[2]));
    rr_decoder_arbiter #(.MAX_HOLD(1), .TURN_CYCLES(15)) dut3 (
        .clk(clk), .reset(reset), .req(req), .grant(grant_w[3]),
        .grant_addr(addr_w[3]), .grant_valid(valid_w[3]), .busy(busy_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rr_winner(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    function automatic void model_step(input int k, input logic [3:0] r);
        logic [3:0] others;
        int w;
        if (m_owner[k] >= 0) begin
            others = r & ~(4'b0001 << m_owner[k]);
            if (!r[m_owner[k]] || (MH[k] != 0 && m_held[k] >= MH[k] && others != 4'b0000)) begin
                m_ptr[k]   = (m_owner[k] + 1) % 4;
                m_owner[k] = -1;
                m_gap[k]   = 1;
            end else begin
                m_held[k]++;
            end
        end else if (m_gap[k] > 0 && m_gap[k] < TC[k]) begin
            m_gap[k]++;
        end else begin
            m_gap[k] = 0;
            w = rr_winner(r, m_ptr[k]);
            if (w >= 0) begin
                m_owner[k] = w;
                m_last[k]  = w;
                m_held[k]  = 1;
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_INST; k++) begin
                m_owner[k] = -1;
                m_held[k]  = 0;
                m_gap[k]   = 0;
                m_ptr[k]   = 0;
                m_last[k]  = 0;
            end
        end else begin
            for (int k = 0; k < N_INST; k++) model_step(k, req);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (grant_w[0] !== 4'b0000 || valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || addr_w[0] !== 2'd0) begin
                failures++;
                $display("[TB] FAIL reset_idle c=%0d got grant=%b valid=%b busy=%b addr=%0d exp 0000/0/0/0",
                         c, grant_w[0], valid_w[0], busy_w[0], addr_w[0]);
            end
        end
    endtask

    task automatic test_single_release();
        req = 4'b0100;
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            checks++;
            if (grant_w[0] !== 4'b0100 || addr_w[0] !== 2'd2 || busy_w[0] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL single_hold e=%0d got grant=%b addr=%0d busy=%b exp 0100/2/1",
                         e, grant_w[0], addr_w[0], busy_w[0]);
            end
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (grant_w[0] !== 4'b0000 || busy_w[0] !== 1'b1 || addr_w[0] !== 2'd2) begin
            failures++;
            $display("[TB] FAIL single_turn got grant=%b busy=%b addr=%0d exp 0000/1/2",
                     grant_w[0], busy_w[0], addr_w[0]);
        end
        @(negedge clk);
        checks++;
        if (busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_idle got busy=%b valid=%b exp 0/0", busy_w[0], valid_w[0]);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            exp_g = (c % 5 == 4) ? 4'b0000 : (4'b0001 << ((c / 5) % 4));
            checks++;
            if (grant_w[1] !== exp_g) begin
                failures++;
                $display("[TB] FAIL rotation c=%0d got=%b exp=%b", c, grant_w[1], exp_g);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_no_preempt_alone();
        do_reset();
        req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (grant_w[1] !== 4'b0010) begin
                failures++;
                $display("[TB] FAIL alone_hold c=%0d got=%b exp=0010", c, grant_w[1]);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_pointer_fairness();
        do_reset();
        req = 4'b1000;
        @(negedge clk);
        checks++;
        if (grant_w[0] !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL fair_first got=%b exp=1000", grant_w[0]);
        end
        req = 4'b0000;
        @(negedge clk);
        req = 4'b1001;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (grant_w[0] !== 4'b0001 || addr_w[0] !== 2'd0) begin
                failures++;
                $display("[TB] FAIL fair_zero got grant=%b addr=%0d exp 0001/0", grant_w[0], addr_w[0]);
            end
        end
        req = 4'b1000;
        @(negedge clk);
        req = 4'b1001;
        @(negedge clk);
        checks++;
        if (grant_w[0] !== 4'b1000 || addr_w[0] !== 2'd3) begin
            failures++;
            $display("[TB] FAIL fair_three got grant=%b addr=%0d exp 1000/3", grant_w[0], addr_w[0]);
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b1000;
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (grant_w[0] !== 4'b0000 || valid_w[0] !== 1'b0 || busy_w[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_reset got grant=%b valid=%b busy=%b exp 0000/0/0",
                     grant_w[0], valid_w[0], busy_w[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        req   = 4'b1010;
        @(negedge clk);
        checks++;
        if (grant_w[0] !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL post_reset_ptr got=%b exp=0010", grant_w[0]);
        end
        req = 4'b0000;
    endtask

    task automatic test_random();
        logic [3:0] exp_g;
        logic [1:0] exp_a;
        logic       exp_v;
        logic       exp_b;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int k = 0; k < N_INST; k++) begin
                exp_v = (m_owner[k] >= 0);
                exp_g = exp_v ? (4'b0001 << m_owner[k]) : 4'b0000;
                exp_a = 2'(m_last[k]);
                exp_b = exp_v || (m_gap[k] > 0);
                checks++;
                if (grant_w[k] !== exp_g || addr_w[k] !== exp_a || valid_w[k] !== exp_v || busy_w[k] !== exp_b) begin
                    failures++;
                    $display("[TB] FAIL random c=%0d inst=%0d got %b/%0d/%b/%b exp %b/%0d/%b/%b",
                             c, k, grant_w[k], addr_w[k], valid_w[k], busy_w[k],
                             exp_g, exp_a, exp_v, exp_b);
                end
            end
            if ($urandom_range(0, 9) >= 7) begin
                req = ($urandom_range(0, 4) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
            end
        end
        req = 4'b0000;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        req      = 4'b0000;
        test_reset();
        test_single_release();
        test_rotation();
        test_no_preempt_alone();
        test_pointer_fairness();
        test_reset_mid_grant();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
